instr_prefetch_buffer: RTL and testbench

- Sits directly upstream of instruction_fetch, between instruction memory and the fetch stage.
- Issues sequential word fetches to instruction memory over a req/ack handshake and queues the returned instructions with their PCs.
- Presents queued instructions to the fetch stage through a valid/ready interface.
- On a branch/jump redirect, flushes the queue and restarts fetching at the new PC.

---
 rtl/risc_pkg.sv | 19 +
 rtl/instr_prefetch_buffer_if.sv | 32 +++
 rtl/prefetch_fifo.sv | 51 +++++
 rtl/instr_prefetch_buffer.sv | 108 ++++++++++
 tb/tb_instr_prefetch_buffer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the instruction-side front end: word width, reset PC,
// prefetch FSM encoding and PC arithmetic.
package risc_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } pf_state_t;

   // Word-addressed sequential fetch; wraps modulo 2^WORD_W.
   function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
      return pc + WORD_W'(1);
   endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Bundle of the memory-side req/ack bus, the fetch-side valid/ready bus and the
// redirect strobe seen by the prefetch buffer.
interface instr_prefetch_buffer_if #(
   parameter int DEPTH = 4
) ();
   import risc_pkg::*;

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ack;
   logic [WORD_W-1:0] imem_rdata;
   logic              inst_valid;
   logic [WORD_W-1:0] inst_data;
   logic [WORD_W-1:0] inst_pc;
   logic              inst_ready;
   logic              redirect_valid;
   logic [WORD_W-1:0] redirect_pc;
   logic [OCC_W-1:0]  occupancy;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc, occupancy,
      input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, occupancy,
      output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, data} entries; head read straight from
// storage, flush beats push and pop.
module prefetch_fifo
   import risc_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 2 * WORD_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [ENTRY_W-1:0]           push_entry,
   output logic [ENTRY_W-1:0]           head_entry,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_pop;

   // A pop on an empty queue is dropped here so callers need not gate it.
   assign do_pop     = pop && (count != '0);
   assign head_entry = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: fetches words over req/ack, queues them
// with their PCs for the fetch stage, and restarts on redirect.
module instr_prefetch_buffer
   import risc_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input logic                     clk,
   input logic                     reset,
   instr_prefetch_buffer_if.master bus
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   pf_state_t           state;
   logic                req_q;
   logic [WORD_W-1:0]   fetch_pc;
   logic [WORD_W-1:0]   drop_pc;
   logic [OCC_W-1:0]    occ;
   logic [2*WORD_W-1:0] head;
   logic                valid;
   logic                ack_req;
   logic                pop;
   logic                push;
   logic                room_after;

   // Acks outside an active request are strays and never touch state.
   assign ack_req    = bus.imem_ack && req_q;
   assign valid      = (occ != '0);
   assign pop        = bus.inst_ready && valid;
   assign push       = ack_req && (state == REQ) && !bus.redirect_valid;
   assign room_after = (occ + OCC_W'(1) - (pop ? OCC_W'(1) : OCC_W'(0))) < OCC_W'(DEPTH);

   prefetch_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (2 * WORD_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (bus.redirect_valid),
      .push_entry ({bus.imem_addr, bus.imem_rdata}),
      .head_entry (head),
      .count      (occ)
   );

   // A request is only raised with a free slot reserved for its response, so
   // the queue can never overflow; a redirected request is finished in DROP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         req_q    <= 1'b0;
         fetch_pc <= RESET_PC;
         drop_pc  <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (bus.redirect_valid) begin
                  fetch_pc <= bus.redirect_pc;
                  state    <= REQ;
                  req_q    <= 1'b1;
               end else if (occ < OCC_W'(DEPTH)) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end
            REQ: begin
               if (ack_req) begin
                  if (bus.redirect_valid) begin
                     fetch_pc <= bus.redirect_pc;
                  end else begin
                     fetch_pc <= pc_next(fetch_pc);
                     if (!room_after) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                     end
                  end
               end else if (bus.redirect_valid) begin
                  drop_pc <= bus.redirect_pc;
                  state   <= DROP;
               end
            end
            DROP: begin
               if (ack_req) begin
                  fetch_pc <= bus.redirect_valid ? bus.redirect_pc : drop_pc;
                  state    <= REQ;
               end else if (bus.redirect_valid) begin
                  drop_pc <= bus.redirect_pc;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = fetch_pc;
   assign bus.occupancy  = occ;
   assign bus.inst_valid = valid;
   assign bus.inst_pc    = valid ? head[2*WORD_W-1:WORD_W] : '0;
   assign bus.inst_data  = valid ? head[WORD_W-1:0] : '0;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed scenarios plus random
// traffic, scored against a queue-level model of the fetch stream.
module tb_instr_prefetch_buffer;
   import risc_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [15:0] RPC   = 16'h0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

   instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus knobs
   bit          rst_in, ready_in, redir_in, stray_en;
   logic [15:0] redir_pc_in;
   int          lat_min, lat_max, cur_lat, wait_cnt;

   // reference model state
   logic [31:0] q[$];
   logic [31:0] delivered[$];
   logic [15:0] exp_addr, drop_pc_m, prev_addr;
   bit          drop_pend, prev_req, prev_ack, live;
   bit          valid_seen, last_acc, last_vld;
   int          gaps, acks_seen;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: score the state left by the previous edge, then drive inputs
   // and advance the model to what the next edge must produce.
   task automatic cycle();
      logic        ack, acc, pop, push;
      logic [15:0] rdata;
      @(negedge clk);
      if (live) begin
         check("occupancy", 32'(bus.occupancy), 32'(q.size()));
         check("inst_valid", 32'(bus.inst_valid), 32'(q.size() != 0));
         if (q.size() != 0) check("head", {bus.inst_pc, bus.inst_data}, q[0]);
         if (bus.imem_req) check("issue_rule", 32'(q.size() < DEPTH), 32'd1);
         if (prev_req && !prev_ack) begin
            check("req_held", 32'(bus.imem_req), 32'd1);
            check("addr_held", 32'(bus.imem_addr), 32'(prev_addr));
         end else if (bus.imem_req) begin
            check("req_addr", 32'(bus.imem_addr), 32'(exp_addr));
         end
         if (bus.inst_valid) valid_seen = 1'b1;
         else if (valid_seen) gaps++;
      end

      reset              = rst_in;
      bus.inst_ready     = ready_in;
      bus.redirect_valid = redir_in;
      bus.redirect_pc    = redir_pc_in;
      ack = 1'b0;
      if (rst_in) begin
         wait_cnt = 0;
      end else if (bus.imem_req) begin
         if (wait_cnt == 0) cur_lat = int'($urandom_range(lat_max, lat_min));
         if (wait_cnt >= cur_lat) begin
            ack = 1'b1;
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
         if (stray_en && $urandom_range(9, 0) == 0) ack = 1'b1;
      end
      acc   = ack && bus.imem_req;
      rdata = acc ? mem_word(bus.imem_addr) : 16'($urandom);
      bus.imem_ack   = ack;
      bus.imem_rdata = rdata;

      if (rst_in) begin
         q.delete();
         exp_addr  = RPC;
         drop_pend = 1'b0;
         prev_req  = 1'b0;
         prev_ack  = 1'b0;
         live      = 1'b1;
      end else begin
         pop  = ready_in && (q.size() != 0) && !redir_in;
         push = 1'b0;
         last_acc = acc;
         last_vld = bus.inst_valid;
         if (pop) delivered.push_back({bus.inst_pc, bus.inst_data});
         if (acc) begin
            acks_seen++;
            if (redir_in)       exp_addr = redir_pc_in;
            else if (drop_pend) exp_addr = drop_pc_m;
            else                exp_addr = 16'(bus.imem_addr + 16'd1);
            push      = !redir_in && !drop_pend;
            drop_pend = 1'b0;
         end else if (redir_in) begin
            if (bus.imem_req) begin
               drop_pend = 1'b1;
               drop_pc_m = redir_pc_in;
            end else begin
               exp_addr = redir_pc_in;
            end
         end
         if (redir_in) begin
            q.delete();
         end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back({bus.imem_addr, rdata});
         end
         prev_req  = bus.imem_req;
         prev_ack  = acc;
         prev_addr = bus.imem_addr;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic redirect_to(input logic [15:0] pc);
      redir_in    = 1'b1;
      redir_pc_in = pc;
      cycle();
      redir_in    = 1'b0;
   endtask

   initial begin
      bit found;
      int hits;
      rst_in = 1'b1; ready_in = 1'b0; redir_in = 1'b0; redir_pc_in = '0;
      stray_en = 1'b0; lat_min = 0; lat_max = 0; cur_lat = 0; wait_cnt = 0;
      live = 1'b0; drop_pend = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
      exp_addr = RPC; drop_pc_m = '0; prev_addr = '0; gaps = 0; acks_seen = 0;
      reset = 1'b1;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0; bus.redirect_pc = '0;

      // reset state
      run(3);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", 32'(bus.imem_addr), 32'(RPC));
      check("rst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_data", 32'(bus.inst_data), 32'd0);
      check("rst_pc", 32'(bus.inst_pc), 32'd0);
      check("rst_occ", 32'(bus.occupancy), 32'd0);

      // zero-wait stream
      rst_in = 1'b0; ready_in = 1'b1; valid_seen = 1'b0; gaps = 0;
      delivered.delete();
      run(30);
      check("stream_gaps", 32'(gaps), 32'd0);
      check("stream_count", 32'(delivered.size() >= 20), 32'd1);
      if (delivered.size() >= 3) begin
         check("stream_0", delivered[0], 32'h0000_A5A5);
         check("stream_1", delivered[1], 32'h0001_A5A4);
         check("stream_2", delivered[2], 32'h0002_A5A7);
      end

      // backpressure: fill from empty, then one pop with refill
      ready_in = 1'b0;
      redirect_to(16'h0100);
      acks_seen = 0;
      run(12);
      check("bp_acks", 32'(acks_seen), 32'd4);
      check("bp_occ", 32'(bus.occupancy), 32'd4);
      check("bp_req", 32'(bus.imem_req), 32'd0);
      check("bp_head", {bus.inst_pc, bus.inst_data}, {16'h0100, mem_word(16'h0100)});
      ready_in = 1'b1;
      cycle();
      ready_in = 1'b0;
      run(6);
      check("bp_refill_occ", 32'(bus.occupancy), 32'd4);
      check("bp_refill_head", 32'(bus.inst_pc), 32'h0101);

      // redirect while a slow request is outstanding
      lat_min = 3; lat_max = 3; ready_in = 1'b1;
      redirect_to(16'h0010);
      delivered.delete();
      redirect_to(16'h0200);
      check("mid_req_addr", 32'(bus.imem_addr), 32'h0010);
      cycle();
      check("mid_occ", 32'(bus.occupancy), 32'd0);
      check("mid_valid", 32'(bus.inst_valid), 32'd0);
      check("mid_addr_hold", 32'(bus.imem_addr), 32'h0010);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (bus.imem_req && bus.imem_addr == 16'h0200) found = 1'b1;
      end
      check("mid_new_req", 32'(found), 32'd1);
      run(20);
      hits = 0;
      foreach (delivered[i]) if (delivered[i][31:16] == 16'h0010) hits++;
      check("mid_no_stale", 32'(hits), 32'd0);
      check("mid_first", 32'(delivered.size() > 0 ? delivered[0][31:16] : 16'hDEAD), 32'h0200);

      // redirect coinciding with ack and pop
      lat_min = 0; lat_max = 0;
      run(10);
      redirect_to(16'h0300);
      check("coin_ack", 32'(last_acc), 32'd1);
      check("coin_valid", 32'(last_vld), 32'd1);
      cycle();
      check("coin_occ", 32'(bus.occupancy), 32'd0);
      check("coin_req", 32'(bus.imem_req), 32'd1);
      check("coin_addr", 32'(bus.imem_addr), 32'h0300);

      // address wrap
      redirect_to(16'hFFFE);
      delivered.delete();
      run(12);
      check("wrap_count", 32'(delivered.size() >= 4), 32'd1);
      if (delivered.size() >= 4) begin
         check("wrap_0", delivered[0], {16'hFFFE, mem_word(16'hFFFE)});
         check("wrap_1", delivered[1], {16'hFFFF, mem_word(16'hFFFF)});
         check("wrap_2", delivered[2], {16'h0000, mem_word(16'h0000)});
         check("wrap_3", delivered[3], {16'h0001, mem_word(16'h0001)});
      end

      // reset while discarding a redirected request
      lat_min = 3; lat_max = 3;
      redirect_to(16'h0050);
      cycle();
      check("drop_req", 32'(bus.imem_req), 32'd1);
      check("drop_occ", 32'(bus.occupancy), 32'd0);
      rst_in = 1'b1;
      run(2);
      rst_in = 1'b0;
      check("drst_addr", 32'(bus.imem_addr), 32'(RPC));
      check("drst_occ", 32'(bus.occupancy), 32'd0);
      check("drst_valid", 32'(bus.inst_valid), 32'd0);
      check("drst_req", 32'(bus.imem_req), 32'd0);
      lat_min = 0; lat_max = 0;
      delivered.delete();
      run(20);
      check("drst_first", 32'(delivered.size() > 0 ? delivered[0] : 32'hDEAD_DEAD),
            {RPC, mem_word(RPC)});

      // random traffic
      lat_min = 0; lat_max = 3; stray_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         ready_in    = ($urandom_range(99, 0) < 60);
         redir_in    = ($urandom_range(99, 0) < 4);
         redir_pc_in = ($urandom_range(3, 0) == 0) ? 16'($urandom_range(16'hFFFF, 16'hFFFC))
                                                   : 16'($urandom);
         rst_in      = ($urandom_range(999, 0) == 0);
         cycle();
      end
      rst_in = 1'b0; redir_in = 1'b0; ready_in = 1'b1; stray_en = 1'b0;
      run(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
